// File: rtl/scanner_pkg.sv
// scanner_pkg: state codes, error codes and decode helpers shared by the
// lot sequencer, the scanner top level and its monitors.
package scanner_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ENV_CHECK  = 4'd1,
        ST_LOAD_RET   = 4'd2,
        ST_LOAD_WFR   = 4'd3,
        ST_SETUP      = 4'd4,
        ST_ALIGN      = 4'd5,
        ST_EXPOSE     = 4'd6,
        ST_UNLOAD     = 4'd7,
        ST_UNLOAD_RET = 4'd8,
        ST_ERROR      = 4'd15
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_INTERLOCK = 2'd1;
    localparam logic [1:0] ERR_ALIGN     = 2'd2;

    // Environment is qualified once the reticle handling has started and
    // until the reticle is unloaded; never in IDLE, ENV_CHECK or ERROR.
    function automatic logic env_qualified(state_t s);
        return (s inside {ST_LOAD_RET, ST_LOAD_WFR, ST_SETUP, ST_ALIGN,
                          ST_EXPOSE, ST_UNLOAD, ST_UNLOAD_RET});
    endfunction

endpackage

// File: rtl/scanner_step_timer.sv
// scanner_step_timer: loadable down-counter that times the dwell of each
// sequencer step. done_o is high while the count is zero; a load takes
// priority over counting so a state can be re-entered back to back.
module scanner_step_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/scanner_lot_seq.sv
// scanner_lot_seq: lot-level scanner sequencer. Runs ENV_CHECK, LOAD_RET,
// then per wafer LOAD_WFR/SETUP/ALIGN/EXPOSE(xFIELDS)/UNLOAD, then UNLOAD_RET.
// Optional feature macro SCANNER_ALIGN_RETRY_EN: a failed alignment re-runs
// ALIGN up to MAX_ALIGN_RETRY times per wafer before raising ERR_ALIGN.
module scanner_lot_seq
    import scanner_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int WFR_W           = 8,
    parameter int FLD_W           = 6,
    parameter int FIELDS          = 4,
    parameter int T_ENV           = 8,
    parameter int T_LOAD          = 8,
    parameter int T_SETUP         = 8,
    parameter int T_ALIGN         = 8,
    parameter int T_EXPOSE        = 8,
    parameter int T_UNLOAD        = 8,
    parameter int MAX_ALIGN_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start_btn,
    input  logic [WFR_W-1:0] lot_size,
    input  logic             interlock_sig,
    input  logic             align_fail,
    input  logic             err_clear,
    output logic [3:0]       current_process,
    output logic             source_status,
    output logic             env_status,
    output logic [WFR_W-1:0] wafer_idx,
    output logic [FLD_W-1:0] field_idx,
    output logic             lot_done,
    output logic [1:0]       err_code
);

    // Timer reload values: a state lasting T cycles starts its count at T-1.
    localparam logic [CNT_W-1:0] LD_ENV    = CNT_W'(T_ENV - 1);
    localparam logic [CNT_W-1:0] LD_LOAD   = CNT_W'(T_LOAD - 1);
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_ALIGN  = CNT_W'(T_ALIGN - 1);
    localparam logic [CNT_W-1:0] LD_EXPOSE = CNT_W'(T_EXPOSE - 1);
    localparam logic [CNT_W-1:0] LD_UNLOAD = CNT_W'(T_UNLOAD - 1);
    localparam logic [FLD_W-1:0] FLD_LAST  = FLD_W'(FIELDS - 1);

    state_t           state_q, state_d;
    logic [WFR_W-1:0] wafer_q, wafer_d;
    logic [FLD_W-1:0] field_q, field_d;
    logic [WFR_W-1:0] lot_q, lot_d;
    logic [1:0]       err_q, err_d;
    logic             lot_done_q, lot_done_d;
    logic             src_q, env_q;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             more_wafers;

`ifdef SCANNER_ALIGN_RETRY_EN
    localparam int RTY_W = (MAX_ALIGN_RETRY < 1) ? 1 : $clog2(MAX_ALIGN_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_ALIGN_RETRY);
    logic [RTY_W-1:0] retry_q, retry_d;
`else
    localparam int unused_max_align_retry = MAX_ALIGN_RETRY;
`endif

    scanner_step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Extra bit so wafer_idx+1 cannot wrap when the lot fills the index range.
    assign more_wafers = ({1'b0, wafer_q} + 1'b1) < {1'b0, lot_q};

    // Next-state, counters and timer reload. Interlock beats every timed exit;
    // align_fail only matters on the last ALIGN cycle (timer expiry).
    always_comb begin
        state_d    = state_q;
        wafer_d    = wafer_q;
        field_d    = field_q;
        lot_d      = lot_q;
        err_d      = err_q;
        lot_done_d = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef SCANNER_ALIGN_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_start_btn && !interlock_sig && (lot_size != '0)) begin
                    state_d  = ST_ENV_CHECK;
                    lot_d    = lot_size;
                    wafer_d  = '0;
                    field_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ENV;
                end
            end
            ST_ERROR: begin
                // Clearing aborts the lot: indices go back to the first wafer.
                if (err_clear && !interlock_sig) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                    wafer_d = '0;
                    field_d = '0;
`ifdef SCANNER_ALIGN_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            default: begin
                if (interlock_sig) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_INTERLOCK;
                end else if (tmr_done) begin
                    tmr_load = 1'b1;
                    case (state_q)
                        ST_ENV_CHECK: begin
                            state_d = ST_LOAD_RET;
                            tmr_val = LD_LOAD;
                        end
                        ST_LOAD_RET: begin
                            state_d = ST_LOAD_WFR;
                            tmr_val = LD_LOAD;
`ifdef SCANNER_ALIGN_RETRY_EN
                            retry_d = '0;
`endif
                        end
                        ST_LOAD_WFR: begin
                            state_d = ST_SETUP;
                            tmr_val = LD_SETUP;
                        end
                        ST_SETUP: begin
                            state_d = ST_ALIGN;
                            tmr_val = LD_ALIGN;
                        end
                        ST_ALIGN: begin
                            if (align_fail) begin
`ifdef SCANNER_ALIGN_RETRY_EN
                                // Stay in ALIGN with a fresh dwell while retries remain.
                                if (retry_q < RTY_MAX) begin
                                    tmr_val = LD_ALIGN;
                                    retry_d = retry_q + 1'b1;
                                end else begin
                                    state_d = ST_ERROR;
                                    err_d   = ERR_ALIGN;
                                end
`else
                                state_d = ST_ERROR;
                                err_d   = ERR_ALIGN;
`endif
                            end else begin
                                state_d = ST_EXPOSE;
                                field_d = '0;
                                tmr_val = LD_EXPOSE;
                            end
                        end
                        ST_EXPOSE: begin
                            // Each field gets its own dwell; leave after the last one.
                            tmr_val = LD_EXPOSE;
                            if (field_q == FLD_LAST) begin
                                state_d = ST_UNLOAD;
                                tmr_val = LD_UNLOAD;
                            end else begin
                                field_d = field_q + 1'b1;
                            end
                        end
                        ST_UNLOAD: begin
                            if (more_wafers) begin
                                state_d = ST_LOAD_WFR;
                                wafer_d = wafer_q + 1'b1;
                                tmr_val = LD_LOAD;
`ifdef SCANNER_ALIGN_RETRY_EN
                                retry_d = '0;
`endif
                            end else begin
                                state_d = ST_UNLOAD_RET;
                                tmr_val = LD_UNLOAD;
                            end
                        end
                        ST_UNLOAD_RET: begin
                            state_d    = ST_IDLE;
                            lot_done_d = 1'b1;
                            tmr_load   = 1'b0;
                        end
                        default: begin
                            state_d  = ST_IDLE;
                            tmr_load = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    // State and registered outputs; output flags are decoded from next state
    // so they line up with current_process.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wafer_q    <= '0;
            field_q    <= '0;
            lot_q      <= '0;
            err_q      <= ERR_NONE;
            lot_done_q <= 1'b0;
            src_q      <= 1'b0;
            env_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wafer_q    <= wafer_d;
            field_q    <= field_d;
            lot_q      <= lot_d;
            err_q      <= err_d;
            lot_done_q <= lot_done_d;
            src_q      <= (state_d == ST_EXPOSE);
            env_q      <= env_qualified(state_d);
        end
    end

`ifdef SCANNER_ALIGN_RETRY_EN
    // Per-wafer alignment retry count.
    always_ff @(posedge clk) begin
        if (reset) retry_q <= '0;
        else       retry_q <= retry_d;
    end
`endif

    assign current_process = state_q;
    assign source_status   = src_q;
    assign env_status      = env_q;
    assign wafer_idx       = wafer_q;
    assign field_idx       = field_q;
    assign lot_done        = lot_done_q;
    assign err_code        = err_q;

endmodule

// File: tb/tb_scanner_lot_seq.sv
// tb_scanner_lot_seq: scenario table plus randomized lots. The expected
// per-cycle trace is expanded from a schedule of (state, dwell) steps.
module tb_scanner_lot_seq;
    import scanner_pkg::*;

    localparam int CNT_W = 16, WFR_W = 8, FLD_W = 6, FIELDS = 2;
    localparam int T_ENV = 4, T_LOAD = 3, T_SETUP = 2, T_ALIGN = 3, T_EXPOSE = 5, T_UNLOAD = 3;
    localparam int MAX_RTY = 2;
`ifdef SCANNER_ALIGN_RETRY_EN
    localparam int ALLOW = MAX_RTY;
`else
    localparam int ALLOW = 0;
`endif

    logic clk = 1'b0;
    logic reset, op_start_btn, interlock_sig, align_fail, err_clear;
    logic [WFR_W-1:0] lot_size;
    logic [3:0] current_process;
    logic source_status, env_status, lot_done;
    logic [WFR_W-1:0] wafer_idx;
    logic [FLD_W-1:0] field_idx;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    scanner_lot_seq #(
        .CNT_W(CNT_W), .WFR_W(WFR_W), .FLD_W(FLD_W), .FIELDS(FIELDS),
        .T_ENV(T_ENV), .T_LOAD(T_LOAD), .T_SETUP(T_SETUP), .T_ALIGN(T_ALIGN),
        .T_EXPOSE(T_EXPOSE), .T_UNLOAD(T_UNLOAD), .MAX_ALIGN_RETRY(MAX_RTY)
    ) dut (
        .clk(clk), .reset(reset), .op_start_btn(op_start_btn), .lot_size(lot_size),
        .interlock_sig(interlock_sig), .align_fail(align_fail), .err_clear(err_clear),
        .current_process(current_process), .source_status(source_status),
        .env_status(env_status), .wafer_idx(wafer_idx), .field_idx(field_idx),
        .lot_done(lot_done), .err_code(err_code)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] st;
        int         wafer;
        int         field;
        bit         src;
        bit         env;
        bit         done;
        logic [1:0] err;
        bit         af;
        bit         il;
    } exp_t;

    typedef struct {
        int         lot;
        int         f0, f1, f2;
        int         ilk;
        int         exp_len;
        logic [3:0] exp_st;
        logic [1:0] exp_err;
        int         exp_w;
    } vec_t;

    exp_t q[$];
    int m_wafer, m_field;

    function automatic logic [31:0] pack(logic [3:0] st, bit src, bit env, bit done,
                                         logic [1:0] err, int w, int f);
        return {9'd0, st, src, env, done, err, w[7:0], f[5:0]};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(current_process, source_status, env_status, lot_done, err_code,
                    int'(wafer_idx), int'(field_idx));
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", name, idx, got, exp);
        end
    endtask

    // Append n cycles of one state; align_fail is noise except on the last cycle.
    task automatic push(input logic [3:0] st, input int n, input bit af_last);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.st = st; e.wafer = m_wafer; e.field = m_field;
            e.src = (st == ST_EXPOSE);
            e.env = (st >= 4'd2 && st <= 4'd8);
            e.done = 1'b0; e.err = ERR_NONE; e.il = 1'b0;
            e.af = (i == n - 1) ? af_last : 1'($urandom_range(0, 1));
            q.push_back(e);
        end
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.st = ST_ERROR; e.wafer = m_wafer; e.field = m_field;
        e.src = 1'b0; e.env = 1'b0; e.done = 1'b0; e.err = code;
        e.af = 1'($urandom_range(0, 1)); e.il = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_idle(input bit done);
        exp_t e;
        e.st = ST_IDLE; e.wafer = m_wafer; e.field = m_field;
        e.src = 1'b0; e.env = 1'b0; e.done = done; e.err = ERR_NONE;
        e.af = 1'($urandom_range(0, 1)); e.il = 1'b0;
        q.push_back(e);
    endtask

    // Expand a lot into its expected cycle trace; fl[w] = align failures on wafer w.
    task automatic build(input int lot, input int fl0, input int fl1, input int fl2);
        int fl[3];
        fl[0] = fl0; fl[1] = fl1; fl[2] = fl2;
        q.delete();
        m_wafer = 0; m_field = 0;
        push(ST_ENV_CHECK, T_ENV, 1'b0);
        push(ST_LOAD_RET, T_LOAD, 1'b0);
        for (int w = 0; w < lot; w++) begin
            m_wafer = w;
            push(ST_LOAD_WFR, T_LOAD, 1'b0);
            push(ST_SETUP, T_SETUP, 1'b0);
            for (int a = 0; a <= ALLOW; a++) begin
                push(ST_ALIGN, T_ALIGN, a < fl[w]);
                if (a >= fl[w]) break;
            end
            if (fl[w] > ALLOW) begin
                push_err(ERR_ALIGN);
                return;
            end
            for (int f = 0; f < FIELDS; f++) begin
                m_field = f;
                push(ST_EXPOSE, T_EXPOSE, 1'b0);
            end
            push(ST_UNLOAD, T_UNLOAD, 1'b0);
        end
        push(ST_UNLOAD_RET, T_UNLOAD, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
    endtask

    // Run one lot, comparing every cycle; ilk = -1 none, -2 random, else cycle index.
    task automatic run_scn(input int lot, input int fl0, input int fl1, input int fl2,
                           input int ilk_in, output int run_len, output logic [3:0] end_st,
                           output logic [1:0] end_err, output int end_w);
        int ilk, end_i;
        exp_t last;
        ilk = ilk_in;
        build(lot, fl0, fl1, fl2);
        end_i = q.size();
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].st == ST_IDLE || q[i].st == ST_ERROR) end_i = i;
        if (ilk == -2)
            ilk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, end_i - 1)) : -1;
        if (ilk >= 0 && ilk < end_i) begin
            while (q.size() > ilk + 1) void'(q.pop_back());
            q[ilk].il = 1'b1;
            m_wafer = q[ilk].wafer;
            m_field = q[ilk].field;
            push_err(ERR_INTERLOCK);
            q[q.size() - 1].il = 1'b1;
        end
        run_len = -1; end_st = 4'hx; end_err = 2'bxx; end_w = -1;
        @(negedge clk);
        op_start_btn = 1'b1; lot_size = WFR_W'(lot);
        interlock_sig = 1'b0; align_fail = 1'b0; err_clear = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            op_start_btn = 1'b0;
            if (i == 0) lot_size = WFR_W'($urandom);
            check("trace", i, dut_vec(),
                  pack(q[i].st, q[i].src, q[i].env, q[i].done, q[i].err, q[i].wafer, q[i].field));
            if (run_len < 0 && (current_process == ST_IDLE || current_process == ST_ERROR)) begin
                run_len = i; end_st = current_process; end_err = err_code; end_w = int'(wafer_idx);
            end
            align_fail = q[i].af;
            interlock_sig = q[i].il;
        end
        last = q[q.size() - 1];
        if (last.st == ST_ERROR) begin
            if (last.il) begin
                err_clear = 1'b1;
                @(negedge clk);
                check("clr_blocked", 0, {28'd0, current_process}, {28'd0, ST_ERROR});
                check("clr_blocked_err", 0, {30'd0, err_code}, {30'd0, ERR_INTERLOCK});
            end
            interlock_sig = 1'b0; err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
            check("clr_idle", 0, dut_vec(), pack(ST_IDLE, 0, 0, 0, ERR_NONE, 0, 0));
        end
        align_fail = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        int rl, ew;
        logic [3:0] es;
        logic [1:0] ee;
        bit found;

        vt[0] = '{2, 0, 0, 0, -1, 52, ST_IDLE,  ERR_NONE,      1};
        vt[1] = '{1, 0, 0, 0, -1, 31, ST_IDLE,  ERR_NONE,      0};
        vt[2] = '{2, 0, 0, 0, 17, 18, ST_ERROR, ERR_INTERLOCK, 0};
        vt[6] = '{3, 0, 0, 0, 45, 46, ST_ERROR, ERR_INTERLOCK, 1};
`ifdef SCANNER_ALIGN_RETRY_EN
        vt[3] = '{2, 0, 1, 0, -1, 55, ST_IDLE,  ERR_NONE,      1};
        vt[4] = '{2, 2, 0, 0, -1, 58, ST_IDLE,  ERR_NONE,      1};
        vt[5] = '{1, 3, 0, 0, -1, 21, ST_ERROR, ERR_ALIGN,     0};
`else
        vt[3] = '{2, 0, 1, 0, -1, 36, ST_ERROR, ERR_ALIGN,     1};
        vt[4] = '{2, 2, 0, 0, -1, 15, ST_ERROR, ERR_ALIGN,     0};
        vt[5] = '{1, 3, 0, 0, -1, 15, ST_ERROR, ERR_ALIGN,     0};
`endif

        reset = 1'b1; op_start_btn = 1'b0; lot_size = '0;
        interlock_sig = 1'b0; align_fail = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 0, dut_vec(), 32'd0);
        reset = 1'b0;

        // Start with an empty lot, then with interlock active: both ignored.
        op_start_btn = 1'b1; lot_size = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_lot", i, dut_vec(), 32'd0);
        end
        lot_size = 8'd2; interlock_sig = 1'b1;
        @(negedge clk);
        check("start_ilk", 0, dut_vec(), 32'd0);
        op_start_btn = 1'b0; interlock_sig = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_scn(vt[v].lot, vt[v].f0, vt[v].f1, vt[v].f2, vt[v].ilk, rl, es, ee, ew);
            check("vec_len", v, rl, vt[v].exp_len);
            check("vec_end", v, {18'd0, es, ee, ew[7:0]}, {18'd0, vt[v].exp_st, vt[v].exp_err, vt[v].exp_w[7:0]});
        end

        // Reset mid-lot while in SETUP, then a clean lot afterwards.
        @(negedge clk);
        op_start_btn = 1'b1; lot_size = 8'd2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            op_start_btn = 1'b0;
            if (current_process == ST_SETUP) found = 1'b1;
        end
        check("reach_setup", 0, {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_setup", 0, dut_vec(), 32'd0);
        run_scn(2, 0, 0, 0, -1, rl, es, ee, ew);
        check("post_rst_len", 0, rl, 52);

        for (int r = 0; r < 25; r++) begin
            int lot;
            int fl[3];
            lot = int'($urandom_range(1, 3));
            for (int w = 0; w < 3; w++)
                fl[w] = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            run_scn(lot, fl[0], fl[1], fl[2], -2, rl, es, ee, ew);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scanner_lot_seq.md
# scanner_lot_seq

Parametrised lot-level scanner sequencer and next generation of the single-wafer scanner FSM. It runs a full lot of wafers through one reticle load: ENV_CHECK → LOAD_RET → (LOAD_WFR → SETUP → ALIGN → EXPOSE × N fields → UNLOAD) × lot_size → UNLOAD_RET. It adds configurable step durations, multi-field exposure, latched error codes with an explicit clear, and optional align retry. It sits under the scanner top level, driven by operator start and the interlock chain, and reports process state to the status/monitor logic.

## Interface
- CNT_W, 16, width of step down-counter
- WFR_W, 8, width of lot_size / wafer_idx
- FLD_W, 6, width of field_idx
- FIELDS, 4, exposure fields per wafer (1..2^FLD_W-1)
- T_ENV, T_LOAD, T_SETUP, T_ALIGN, T_EXPOSE, T_UNLOAD, 8, dwell cycles per step (≥1). T_EXPOSE is per field; T_LOAD/T_UNLOAD also apply to the reticle steps.
- MAX_ALIGN_RETRY, 2, align retries per wafer (retry build only)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- op_start_btn  in  1  level start request, sampled in IDLE
- lot_size  in  WFR_W  wafers in lot, latched at start
- interlock_sig  in  1  hazard, level
- align_fail  in  1  alignment result, sampled on last ALIGN cycle
- err_clear  in  1  operator acknowledge of ERROR
- current_process  out  4  state code
- source_status  out  1  light source on
- env_status  out  1  environment qualified
- wafer_idx  out  WFR_W  current wafer, 0-based
- field_idx  out  FLD_W  current field, 0-based
- lot_done  out  1  one-cycle pulse on lot completion
- err_code  out  2  0 none, 1 interlock, 2 align

## Operation
- State codes: IDLE 0, ENV_CHECK 1, LOAD_RET 2, LOAD_WFR 3, SETUP 4, ALIGN 5, EXPOSE 6, UNLOAD 7, UNLOAD_RET 8, ERROR 15.
- Reset values: current_process 0, all other outputs 0. Counters and the latched lot size are also cleared.
- IDLE → ENV_CHECK when op_start_btn=1, interlock_sig=0 and lot_size≠0. lot_size is latched on that edge. Otherwise the start is ignored.
- Timed states: the step counter loads T_x−1 on entry. The state exits on the edge where counter==0, so each state occupies exactly T_x cycles.
- EXPOSE: runs FIELDS×T_EXPOSE cycles. field_idx increments at each field boundary and is reset to 0 on ALIGN exit.
- UNLOAD exit:
  - If wafer_idx+1 < latched lot_size: go to LOAD_WFR and increment wafer_idx.
  - Otherwise: go to UNLOAD_RET.
- UNLOAD_RET exit → IDLE, with lot_done=1 for exactly that one cycle in IDLE.
- ALIGN exit with align_fail=1 → ERROR, err_code=2 (see Configuration for the retry build).
- interlock_sig=1 in any state except IDLE/ERROR → ERROR on the next edge, err_code=1.
- ERROR holds until err_clear=1 with interlock_sig=0. Then → IDLE, err_code, wafer_idx and field_idx clear to 0, and the lot is aborted.
- Priority: reset > interlock > align_fail > timer expiry > start.
- source_status = 1 only in EXPOSE.
- env_status = 1 in states 2..8; 0 in IDLE, ENV_CHECK and ERROR.
- Reset mid-lot returns to IDLE on the next edge, with all state discarded.

## Timing
- All outputs are registered and change only on clk edges; current_process is the state register.
- Start sampled at edge e → current_process=1 in the cycle after e.
- Per-wafer cycles: T_LOAD+T_SETUP+T_ALIGN+FIELDS·T_EXPOSE+T_UNLOAD.
- Lot cycles from ENV_CHECK entry to IDLE entry: T_ENV+T_LOAD+lot_size·per-wafer+T_UNLOAD.
- Interlock latency to ERROR is 1 edge; the counter value is discarded.
- Clear latency from err_clear to IDLE is 1 edge.

## Configuration
- SCANNER_ALIGN_RETRY_EN defined:
  - align_fail on the last ALIGN cycle re-enters ALIGN with the counter reloaded while the per-wafer retry count < MAX_ALIGN_RETRY, and increments the retry count.
  - The next failure after that goes → ERROR, err_code=2.
  - The retry count clears on LOAD_WFR entry.
- Undefined: the first align_fail → ERROR, err_code=2. No retry counter is built and MAX_ALIGN_RETRY is ignored.

## Structure
- Package scanner_pkg holds the state code constants and the err_code constants (ERR_NONE, ERR_INTERLOCK, ERR_ALIGN); it is shared with the existing scanner top and its monitors.
- Sub-module scanner_step_timer: a loadable CNT_W down-counter with a load input and a done flag (counter==0); one instance.
- The FSM, wafer/field/retry counters and output decode stay in scanner_lot_seq.

## Test plan
Common parameters: T_ENV=4, T_LOAD=3, T_SETUP=2, T_ALIGN=3, T_EXPOSE=5, FIELDS=2, T_UNLOAD=3.
- Normal lot: lot_size=2, one-cycle start → states 1,2,(3,4,5,6,7)×2,8. IDLE is entered 52 cycles after ENV_CHECK entry, lot_done is high for 1 cycle, wafer_idx reaches 1, and source_status is high for 10 cycles per wafer.
- lot_size=0 with start → remains IDLE; all outputs stay 0.
- Interlock at the 3rd EXPOSE cycle of wafer 0 → current_process=15 on the next edge, err_code=1, source_status=0. err_clear while interlock_sig=1 is ignored. After interlock drops, err_clear → IDLE and err_code=0.
- align_fail on wafer 1 (build without the macro) → ERROR, err_code=2, wafer_idx=1.
- With SCANNER_ALIGN_RETRY_EN, MAX_ALIGN_RETRY=2: two failures → ALIGN repeated, wafer completes 6 cycles late. Three failures → ERROR, err_code=2.
- reset asserted in SETUP → IDLE next edge; wafer_idx=0; a subsequent start runs a full lot correctly.
